// File: rtl/trigger_timer.sv
// Arm-and-fire trigger: after en, watch masked din lines for a filtered trigger level and
// report the firing channel(s) with the elapsed ARMED cycle count, or report a timeout.
module trigger_timer #(
  parameter int   CHANNELS   = 4,
  parameter int   CNT_W      = 32,
  parameter int   FILTER     = 1,
  parameter logic TRIG_LEVEL = 1'b0,
  localparam int  HC_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [CHANNELS-1:0] mask,
  input  logic [CNT_W-1:0]    timeout,
  input  logic [CHANNELS-1:0] din,
  output logic                busy,
  output logic                valid,
  output logic                timed_out,
  output logic [CHANNELS-1:0] hit_mask,
  output logic [HC_W-1:0]     hit_chan,
  output logic [CNT_W-1:0]    count
);

  localparam int FLT_W = $clog2(FILTER + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER - 1);
  localparam logic [FLT_W-1:0] FLT_FULL = FLT_W'(FILTER);

  typedef enum logic {IDLE, ARMED} state_e;

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] mask_l_q, mask_l_d;
  logic [CNT_W-1:0]    timeout_l_q, timeout_l_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FLT_W-1:0]    flt_q [CHANNELS];
  logic [FLT_W-1:0]    flt_d [CHANNELS];
  logic                valid_q, valid_d;
  logic                timed_out_q, timed_out_d;
  logic [CHANNELS-1:0] hit_mask_q, hit_mask_d;
  logic [HC_W-1:0]     hit_chan_q, hit_chan_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CHANNELS-1:0] match, qual;
  logic [HC_W-1:0]     low_idx;

  always_comb begin
    state_d     = state_q;
    mask_l_d    = mask_l_q;
    timeout_l_d = timeout_l_q;
    cnt_d       = cnt_q;
    flt_d       = flt_q;
    valid_d     = 1'b0;
    timed_out_d = 1'b0;
    hit_mask_d  = hit_mask_q;
    hit_chan_d  = hit_chan_q;
    count_d     = count_q;
    match       = '0;
    qual        = '0;
    low_idx     = '0;

    for (int i = 0; i < CHANNELS; i++) begin
      match[i] = mask_l_q[i] && (din[i] == TRIG_LEVEL);
      qual[i]  = match[i] && (flt_q[i] == FLT_LAST);
    end
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (qual[i]) low_idx = HC_W'(i);
    end

    // Arming wins over any hit or timeout on the same edge, and issues no pulse.
    if (en) begin
      state_d     = ARMED;
      mask_l_d    = mask;
      timeout_l_d = timeout;
      cnt_d       = '0;
      for (int i = 0; i < CHANNELS; i++) flt_d[i] = '0;
    end else if (state_q == ARMED) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!match[i])                flt_d[i] = '0;
        else if (flt_q[i] != FLT_FULL) flt_d[i] = flt_q[i] + FLT_W'(1);
      end
      if (|qual) begin
        valid_d    = 1'b1;
        hit_mask_d = qual;
        hit_chan_d = low_idx;
        count_d    = cnt_q;
        state_d    = IDLE;
      end else if ((timeout_l_q != '0) && (cnt_q == timeout_l_q - CNT_W'(1))) begin
        timed_out_d = 1'b1;
        count_d     = timeout_l_q;
        hit_mask_d  = '0;
        state_d     = IDLE;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_l_q    <= '0;
      timeout_l_q <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < CHANNELS; i++) flt_q[i] <= '0;
      valid_q     <= 1'b0;
      timed_out_q <= 1'b0;
      hit_mask_q  <= '0;
      hit_chan_q  <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      mask_l_q    <= mask_l_d;
      timeout_l_q <= timeout_l_d;
      cnt_q       <= cnt_d;
      flt_q       <= flt_d;
      valid_q     <= valid_d;
      timed_out_q <= timed_out_d;
      hit_mask_q  <= hit_mask_d;
      hit_chan_q  <= hit_chan_d;
      count_q     <= count_d;
    end
  end

  assign busy      = (state_q == ARMED);
  assign valid     = valid_q;
  assign timed_out = timed_out_q;
  assign hit_mask  = hit_mask_q;
  assign hit_chan  = hit_chan_q;
  assign count     = count_q;

endmodule

// File: tb/tb_trigger_timer.sv
// Bench for trigger_timer: two instances (FILTER=1/CNT_W=8 and FILTER=3/CNT_W=4) share stimulus
// and are compared every cycle against a run-length based reference model, plus directed checks.
module tb_trigger_timer;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [3:0] mask, din;
  logic [7:0] timeout;

  logic       a_busy, a_valid, a_to;
  logic [3:0] a_hit;
  logic [1:0] a_chan;
  logic [7:0] a_count;
  logic       b_busy, b_valid, b_to;
  logic [3:0] b_hit;
  logic [1:0] b_chan;
  logic [3:0] b_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  trigger_timer #(.CHANNELS(4), .CNT_W(8), .FILTER(1), .TRIG_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mask(mask), .timeout(timeout), .din(din),
    .busy(a_busy), .valid(a_valid), .timed_out(a_to), .hit_mask(a_hit),
    .hit_chan(a_chan), .count(a_count)
  );

  trigger_timer #(.CHANNELS(4), .CNT_W(4), .FILTER(3), .TRIG_LEVEL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mask(mask), .timeout(timeout[3:0]), .din(din),
    .busy(b_busy), .valid(b_valid), .timed_out(b_to), .hit_mask(b_hit),
    .hit_chan(b_chan), .count(b_count)
  );

  // Reference model: per instance, elapsed ARMED edges and per-channel run lengths.
  int         filt [2] = '{1, 3};
  int         maxc [2] = '{255, 15};
  bit         m_armed [2];
  int         m_el [2];
  int         m_run [2][4];
  logic [3:0] m_mask [2];
  int         m_to [2];
  bit         m_valid [2];
  bit         m_tp [2];
  logic [3:0] m_hit [2];
  int         m_chan [2];
  int         m_count [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    for (int u = 0; u < 2; u++) begin
      logic [3:0] qual;
      bit         hit_now;
      qual = '0;
      if (rst) begin
        m_armed[u] = 0; m_el[u] = 0; m_mask[u] = '0; m_to[u] = 0;
        m_valid[u] = 0; m_tp[u] = 0; m_hit[u] = '0; m_chan[u] = 0; m_count[u] = 0;
        for (int c = 0; c < 4; c++) m_run[u][c] = 0;
      end else begin
        m_valid[u] = 0;
        m_tp[u]    = 0;
        if (en) begin
          m_armed[u] = 1;
          m_mask[u]  = mask;
          m_to[u]    = (u == 0) ? int'(timeout) : int'(timeout) % 16;
          m_el[u]    = 0;
          for (int c = 0; c < 4; c++) m_run[u][c] = 0;
        end else if (m_armed[u]) begin
          for (int c = 0; c < 4; c++) begin
            hit_now = m_mask[u][c] && (din[c] == 1'b0);
            if (hit_now && (m_run[u][c] + 1 >= filt[u])) qual[c] = 1'b1;
            m_run[u][c] = hit_now ? m_run[u][c] + 1 : 0;
          end
          if (qual != 0) begin
            m_valid[u] = 1;
            m_hit[u]   = qual;
            for (int c = 3; c >= 0; c--) if (qual[c]) m_chan[u] = c;
            m_count[u] = m_el[u];
            m_armed[u] = 0;
          end else if (m_to[u] != 0 && m_el[u] == m_to[u] - 1) begin
            m_tp[u]    = 1;
            m_count[u] = m_to[u];
            m_hit[u]   = '0;
            m_armed[u] = 0;
          end else if (m_el[u] < maxc[u]) begin
            m_el[u]++;
          end
        end
      end
    end
  endtask

  // One clock edge: advance the model with the inputs the DUTs sample, then compare.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("a_busy",  32'(a_busy),  32'(m_armed[0]));
    check_eq("a_valid", 32'(a_valid), 32'(m_valid[0]));
    check_eq("a_to",    32'(a_to),    32'(m_tp[0]));
    check_eq("a_hit",   32'(a_hit),   32'(m_hit[0]));
    check_eq("a_chan",  32'(a_chan),  32'(m_chan[0]));
    check_eq("a_count", 32'(a_count), 32'(m_count[0]));
    check_eq("b_busy",  32'(b_busy),  32'(m_armed[1]));
    check_eq("b_valid", 32'(b_valid), 32'(m_valid[1]));
    check_eq("b_to",    32'(b_to),    32'(m_tp[1]));
    check_eq("b_hit",   32'(b_hit),   32'(m_hit[1]));
    check_eq("b_chan",  32'(b_chan),  32'(m_chan[1]));
    check_eq("b_count", 32'(b_count), 32'(m_count[1]));
  endtask

  task automatic arm(input logic [3:0] m, input logic [7:0] t, input logic [3:0] d);
    mask = m; timeout = t; din = d; en = 1'b1;
    step();
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mask = '0; timeout = '0; din = '0;

    // Reset held with din toggling
    for (int i = 0; i < 3; i++) begin
      din = 4'($urandom);
      step();
      check_eq("rst_busy",  32'(a_busy | b_busy), 0);
      check_eq("rst_count", 32'(a_count), 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = 4'($urandom);
      step();
      check_eq("idle_pulse", 32'(a_valid | a_to | b_valid | b_to), 0);
    end

    // Basic fire: din=1011 sampled on the 6th ARMED edge
    arm(4'b1111, 8'd0, 4'b1111);
    repeat (5) step();
    din = 4'b1011;
    step();
    check_eq("basic_valid", 32'(a_valid), 1);
    check_eq("basic_count", 32'(a_count), 5);
    check_eq("basic_hit",   32'(a_hit),   4'b0100);
    check_eq("basic_chan",  32'(a_chan),  2);
    step();
    check_eq("basic_busy",  32'(a_busy),  0);
    step();
    check_eq("basic_b_count", 32'(b_count), 7);

    // Glitch filter and multi-hit on the FILTER=3 instance
    arm(4'b1111, 8'd0, 4'b1111);
    din = 4'b1110; repeat (2) step();
    check_eq("glitch_nofire", 32'(b_valid), 0);
    din = 4'b1111; step();
    din = 4'b0101; repeat (3) step();
    check_eq("multi_valid", 32'(b_valid), 1);
    check_eq("multi_hit",   32'(b_hit),   4'b1010);
    check_eq("multi_chan",  32'(b_chan),  1);
    check_eq("multi_count", 32'(b_count), 5);
    din = 4'b1111; step();

    // Timeout with only channel 0 enabled (held high)
    arm(4'b0001, 8'd10, 4'b0001);
    repeat (9) step();
    check_eq("to_early", 32'(a_to | b_to), 0);
    step();
    check_eq("to_a_pulse", 32'(a_to), 1);
    check_eq("to_b_pulse", 32'(b_to), 1);
    check_eq("to_a_count", 32'(a_count), 10);
    check_eq("to_a_hit",   32'(a_hit), 0);
    check_eq("to_a_valid", 32'(a_valid), 0);
    step();

    // Hit on the same edge the timeout would expire
    arm(4'b1111, 8'd6, 4'b1111);
    repeat (5) step();
    din = 4'b1110;
    step();
    check_eq("prio_valid", 32'(a_valid), 1);
    check_eq("prio_to",    32'(a_to),    0);
    check_eq("prio_count", 32'(a_count), 5);
    check_eq("prio_b_to",  32'(b_to),    1);
    din = 4'b1111; repeat (2) step();

    // Re-arm mid-ARMED while a hit is present
    arm(4'b1111, 8'd0, 4'b1111);
    repeat (3) step();
    din = 4'b1110; en = 1'b1;
    step();
    en = 1'b0;
    check_eq("rearm_nopulse", 32'(a_valid | a_to), 0);
    check_eq("rearm_busy",    32'(a_busy), 1);
    step();
    check_eq("rearm_valid", 32'(a_valid), 1);
    check_eq("rearm_count", 32'(a_count), 0);
    din = 4'b1111; repeat (3) step();

    // Counter saturation on the 4-bit instance
    arm(4'b1111, 8'd0, 4'b1111);
    repeat (20) step();
    din = 4'b1110;
    step();
    check_eq("sat_a_count", 32'(a_count), 20);
    repeat (2) step();
    check_eq("sat_b_valid", 32'(b_valid), 1);
    check_eq("sat_b_count", 32'(b_count), 15);
    din = 4'b1111; step();

    // Reset while ARMED
    arm(4'b1111, 8'd0, 4'b1111);
    repeat (3) step();
    rst = 1'b1; din = 4'b0000;
    step();
    check_eq("rstmid_busy",  32'(a_busy | b_busy), 0);
    check_eq("rstmid_pulse", 32'(a_valid | a_to | b_valid | b_to), 0);
    rst = 1'b0; din = 4'b1111;
    step();

    // Randomised traffic
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 15) == 0);
      if (en) begin
        mask    = 4'($urandom);
        timeout = 8'($urandom_range(0, 24));
      end
      if ($urandom_range(0, 3) == 0) din = 4'($urandom) | 4'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
